// File: rtl/rx_decim_pkg.sv
// Shared types and constants for the burst-controlled receive decimator.
package rx_decim_pkg;

    localparam int DEF_RATIO_W = 4;
    localparam int DEF_LEN_W   = 12;
    localparam int DATA_W      = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rx_decim_ctrl_if.sv
// Config, sample-in and sample-out signals of the decimator controller.
interface rx_decim_ctrl_if
    import rx_decim_pkg::*;
#(
    parameter int RATIO_W = DEF_RATIO_W,
    parameter int LEN_W   = DEF_LEN_W
);
    logic [RATIO_W-1:0]       cfg_ratio;
    logic [RATIO_W-1:0]       cfg_phase;
    logic [LEN_W-1:0]         cfg_len;
    logic                     start;
    logic                     abort;
    logic                     in_valid;
    logic signed [DATA_W-1:0] data_in_I;
    logic signed [DATA_W-1:0] data_in_Q;
    logic signed [DATA_W-1:0] data_out_I;
    logic signed [DATA_W-1:0] data_out_Q;
    logic                     out_valid;
    logic                     out_last;
    logic [LEN_W-1:0]         out_idx;
    logic                     busy;
    logic                     done;

    modport master (
        output cfg_ratio, cfg_phase, cfg_len, start, abort,
               in_valid, data_in_I, data_in_Q,
        input  data_out_I, data_out_Q, out_valid, out_last, out_idx, busy, done
    );

    modport slave (
        input  cfg_ratio, cfg_phase, cfg_len, start, abort,
               in_valid, data_in_I, data_in_Q,
        output data_out_I, data_out_Q, out_valid, out_last, out_idx, busy, done
    );
endinterface

// File: rtl/rx_decim_phase_cnt.sv
// Loadable modulo-(r+1) counter advanced by each valid input sample.
module rx_decim_phase_cnt #(
    parameter int W = 4
) (
    input  logic         clk_40mhz,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] modulus_m1,
    output logic         at_zero,
    output logic         at_wrap
);
    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_40mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= (cnt == modulus_m1) ? '0 : cnt + W'(1);
        end
    end

    assign at_zero = (cnt == '0);
    assign at_wrap = (cnt == modulus_m1);
endmodule

// File: rtl/rx_decim_ctrl.sv
// Burst capture controller: FSM, length counter and registered output stage.
module rx_decim_ctrl
    import rx_decim_pkg::*;
#(
    parameter int RATIO_W = DEF_RATIO_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic           clk_40mhz,
    input  logic           rst_n,
    rx_decim_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ALIGN = ST_ALIGN;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]         state, state_nxt;
    logic [RATIO_W-1:0] ratio_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cap_cnt;
    logic [RATIO_W-1:0] phase_c;
    logic [RATIO_W-1:0] load_val;
    logic               accept;
    logic               cap;
    logic               cnt_zero;
    logic               cnt_wrap;

    assign accept  = (state == S_IDLE) && bus.start && !bus.abort;
    assign phase_c = (bus.cfg_phase > bus.cfg_ratio) ? bus.cfg_ratio : bus.cfg_phase;
    // Skipping p samples equals starting the phase counter p steps before its wrap.
    assign load_val = (phase_c == '0) ? '0 : bus.cfg_ratio - phase_c + RATIO_W'(1);
    // Abort wins over a coincident capture; nothing is captured once the last one is out.
    assign cap = (state == S_RUN) && bus.in_valid && cnt_zero && !bus.abort && !bus.out_last;

    rx_decim_phase_cnt #(.W(RATIO_W)) u_phase (
        .clk_40mhz  (clk_40mhz),
        .rst_n      (rst_n),
        .load       (accept),
        .load_val   (load_val),
        .en         (bus.in_valid && (state == S_ALIGN || state == S_RUN)),
        .modulus_m1 (ratio_q),
        .at_zero    (cnt_zero),
        .at_wrap    (cnt_wrap)
    );

    // NOTE: default assignment first, so no path through always_comb leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.cfg_len == '0)    state_nxt = S_DONE;
                    else if (phase_c != '0)   state_nxt = S_ALIGN;
                    else                      state_nxt = S_RUN;
                end
            end
            S_ALIGN: begin
                if (bus.abort)                       state_nxt = S_IDLE;
                else if (bus.in_valid && cnt_wrap)   state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.abort)         state_nxt = S_IDLE;
                else if (bus.out_last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_40mhz or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            ratio_q        <= '0;
            len_q          <= '0;
            cap_cnt        <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.out_idx    <= '0;
            bus.data_out_I <= '0;
            bus.data_out_Q <= '0;
        end else begin
            state         <= state_nxt;
            bus.out_valid <= cap;
            bus.out_last  <= cap && (cap_cnt == len_q - LEN_W'(1));
            if (accept) begin
                ratio_q     <= bus.cfg_ratio;
                len_q       <= bus.cfg_len;
                cap_cnt     <= '0;
                bus.out_idx <= '0;
            end else if (cap) begin
                cap_cnt        <= cap_cnt + LEN_W'(1);
                bus.out_idx    <= cap_cnt;
                bus.data_out_I <= bus.data_in_I;
                bus.data_out_Q <= bus.data_in_Q;
            end
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
endmodule

// File: tb/tb_rx_decim_ctrl.sv
// Directed bench for rx_decim_ctrl with a sample-counting reference model.
module tb_rx_decim_ctrl;
    logic clk_40mhz = 1'b0;
    logic rst_n     = 1'b0;
    logic cmp_en    = 1'b0;

    rx_decim_ctrl_if #(.RATIO_W(4), .LEN_W(12)) bus ();

    rx_decim_ctrl #(.RATIO_W(4), .LEN_W(12)) dut (
        .clk_40mhz (clk_40mhz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk_40mhz = ~clk_40mhz;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int accept_cyc = 0;
    int vcount = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: valid sample n of a burst is captured when n >= p and (n-p) mod (r+1) == 0.
    int m_mode = 0;   // 0 idle, 1 capturing, 2 last delivered, 3 done pulse
    int m_r = 0, m_p = 0, m_l = 0, m_n = 0, m_caps = 0;
    logic exp_valid = 0, exp_last = 0, exp_done = 0, exp_busy = 0;
    logic signed [13:0] exp_i = 0, exp_q = 0;
    int exp_idx = 0;

    always @(posedge clk_40mhz or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_n <= 0; m_caps <= 0;
            exp_valid <= 0; exp_last <= 0; exp_done <= 0; exp_busy <= 0;
            exp_i <= 0; exp_q <= 0; exp_idx <= 0;
        end else begin : step
            int mode, n, caps, idx, ph;
            logic v, l, d;
            logic signed [13:0] di, dq;
            mode = m_mode; n = m_n; caps = m_caps; idx = exp_idx;
            di = exp_i; dq = exp_q; v = 0; l = 0; d = 0;
            case (mode)
                0: if (bus.start && !bus.abort) begin
                    ph = (int'(bus.cfg_phase) > int'(bus.cfg_ratio)) ? int'(bus.cfg_ratio)
                                                                       : int'(bus.cfg_phase);
                    m_r <= int'(bus.cfg_ratio);
                    m_p <= ph;
                    m_l <= int'(bus.cfg_len);
                    idx = 0; n = 0; caps = 0;
                    if (bus.cfg_len == 0) begin mode = 3; d = 1; end
                    else mode = 1;
                end
                1: if (bus.abort) mode = 0;
                   else if (bus.in_valid) begin
                       if (n >= m_p && ((n - m_p) % (m_r + 1)) == 0) begin
                           v = 1; di = bus.data_in_I; dq = bus.data_in_Q;
                           idx = caps; l = (caps == m_l - 1); caps++;
                           if (l) mode = 2;
                       end
                       n++;
                   end
                2: if (bus.abort) mode = 0;
                   else begin mode = 3; d = 1; end
                default: mode = 0;
            endcase
            m_mode <= mode; m_n <= n; m_caps <= caps;
            exp_valid <= v; exp_last <= l; exp_done <= d; exp_busy <= (mode != 0);
            exp_i <= di; exp_q <= dq; exp_idx <= idx;
        end
    end

    always @(posedge clk_40mhz) cyc <= cyc + 1;

    int cap_i[$];
    int cap_idx[$];
    int cap_off[$];
    int done_cnt = 0;
    int done_off = -1;
    int last_val = -1;

    always @(negedge clk_40mhz) begin
        if (cmp_en) begin
            check("out_valid", int'(bus.out_valid), int'(exp_valid));
            check("out_last",  int'(bus.out_last),  int'(exp_last));
            check("done",      int'(bus.done),      int'(exp_done));
            check("busy",      int'(bus.busy),      int'(exp_busy));
            check("data_out_I", int'(bus.data_out_I), int'(exp_i));
            check("data_out_Q", int'(bus.data_out_Q), int'(exp_q));
            check("out_idx",   int'(bus.out_idx),   exp_idx);
        end
        if (bus.out_valid) begin
            cap_i.push_back(int'(bus.data_out_I));
            cap_idx.push_back(int'(bus.out_idx));
            cap_off.push_back(cyc - accept_cyc);
            if (bus.out_last) last_val = int'(bus.data_out_I);
        end
        if (bus.done) begin
            done_cnt++;
            done_off = cyc - accept_cyc;
        end
    end

    task automatic tick();
        @(posedge clk_40mhz);
        #1;
    endtask

    task automatic clear_log();
        cap_i.delete(); cap_idx.delete(); cap_off.delete();
        done_cnt = 0; done_off = -1; last_val = -1;
    endtask

    // Start pulse; config is scrambled afterwards, which the DUT must ignore.
    task automatic start_burst(input int r, input int p, input int len);
        clear_log();
        vcount = 0;
        bus.cfg_ratio = 4'(r); bus.cfg_phase = 4'(p); bus.cfg_len = 12'(len);
        bus.start = 1'b1;
        accept_cyc = cyc + 1;
        tick();
        bus.start = 1'b0;
        bus.cfg_ratio = 4'd0; bus.cfg_phase = 4'd7; bus.cfg_len = 12'd1;
    endtask

    task automatic run(input int ncyc, input bit toggle);
        for (int i = 0; i < ncyc; i++) begin
            bus.in_valid  = toggle ? (i % 2 == 0) : 1'b1;
            bus.data_in_I = 14'(vcount);
            bus.data_in_Q = 14'(-vcount);
            if (bus.in_valid) vcount++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.cfg_ratio = '0; bus.cfg_phase = '0; bus.cfg_len = '0;
        bus.start = 0; bus.abort = 0; bus.in_valid = 0;
        bus.data_in_I = '0; bus.data_in_Q = '0;
        tick();
        cmp_en = 1'b1;
        check("reset busy", int'(bus.busy), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset data_out_I", int'(bus.data_out_I), 0);
        rst_n = 1'b1;
        tick();

        // 4:1 continuous ramp
        start_burst(3, 0, 4);
        run(20, 0);
        check("r4 count", cap_i.size(), 4);
        for (int k = 0; k < cap_i.size() && k < 4; k++) check("r4 data", cap_i[k], 4 * k);
        if (cap_off.size() > 0) check("r4 first offset", cap_off[0], 1);
        check("r4 last value", last_val, 12);
        check("r4 done offset", done_off, 14);
        check("r4 done count", done_cnt, 1);

        // phase 2 with gaps
        start_burst(3, 2, 3);
        run(28, 1);
        check("ph count", cap_i.size(), 3);
        for (int k = 0; k < cap_i.size() && k < 3; k++) begin
            check("ph data", cap_i[k], 2 + 4 * k);
            check("ph idx", cap_idx[k], k);
        end
        check("ph done count", done_cnt, 1);

        // abort after third strobe
        start_burst(1, 0, 8);
        begin : abort_blk
            bit hit;
            hit = 0;
            for (int i = 0; i < 30 && !hit; i++) begin
                bus.in_valid = 1'b1;
                bus.data_in_I = 14'(vcount); bus.data_in_Q = 14'(-vcount);
                vcount++;
                if (bus.out_valid && cap_i.size() == 2) begin
                    bus.abort = 1'b1;
                    hit = 1;
                end
                tick();
                bus.abort = 1'b0;
            end
            check("abort reached", int'(hit), 1);
        end
        check("abort busy drop", int'(bus.busy), 0);
        run(8, 0);
        check("abort count", cap_i.size(), 3);
        check("abort hold data", int'(bus.data_out_I), 4);
        check("abort no done", done_cnt, 0);

        // zero length
        start_burst(3, 0, 0);
        run(5, 0);
        check("L0 done count", done_cnt, 1);
        check("L0 done offset", done_off, 0);
        check("L0 no strobes", cap_i.size(), 0);

        // 1:1 passthrough
        start_burst(0, 0, 5);
        run(10, 0);
        check("r1 count", cap_i.size(), 5);
        for (int k = 0; k < cap_i.size() && k < 5; k++) begin
            check("r1 data", cap_i[k], k);
            check("r1 offset", cap_off[k], k + 1);
        end

        // phase clamp 9 -> 3
        start_burst(3, 9, 2);
        run(16, 0);
        check("clamp count", cap_i.size(), 2);
        if (cap_i.size() == 2) begin
            check("clamp data0", cap_i[0], 3);
            check("clamp data1", cap_i[1], 7);
        end

        // start while busy ignored
        start_burst(3, 0, 2);
        run(2, 0);
        bus.cfg_ratio = 4'd0; bus.cfg_len = 12'd5; bus.start = 1'b1;
        run(1, 0);
        bus.start = 1'b0;
        run(12, 0);
        check("busy-start count", cap_i.size(), 2);
        if (cap_i.size() == 2) check("busy-start data1", cap_i[1], 4);
        check("busy-start done", done_cnt, 1);

        // start with abort in IDLE
        clear_log();
        bus.cfg_len = 12'd3; bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start+abort busy", int'(bus.busy), 0);
        run(6, 0);
        check("start+abort strobes", cap_i.size(), 0);
        check("start+abort done", done_cnt, 0);

        // reset mid-RUN, then a normal burst
        start_burst(1, 0, 8);
        run(4, 0);
        rst_n = 1'b0;
        #1;
        check("rst busy", int'(bus.busy), 0);
        check("rst out_idx", int'(bus.out_idx), 0);
        check("rst data_out_I", int'(bus.data_out_I), 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_burst(0, 0, 2);
        run(6, 0);
        check("post-rst count", cap_i.size(), 2);
        if (cap_i.size() == 2) check("post-rst data1", cap_i[1], 1);
        check("post-rst done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
